// File: rtl/child_resp_collector.sv
// Round-robin collector merging N_SRC child response streams
// into one registered valid/ready output with a transfer counter.
module child_resp_collector #(
   parameter int DATA_W = 8,
   parameter int N_SRC  = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [N_SRC-1:0]        in_valid,
   input  logic [N_SRC*DATA_W-1:0] in_data,
   output logic [N_SRC-1:0]        in_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [2:0]              out_src,
   input  logic                    out_ready,
   output logic [15:0]             xfer_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   state_t            state;
   logic [2:0]        ptr;
   logic [2:0]        gidx;
   logic              gfound;
   logic [N_SRC-1:0]  grant;
   logic              load_en;
   logic              take;
   int                idx;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      gidx   = '0;
      gfound = 1'b0;
      idx    = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!gfound && in_valid[idx[2:0]]) begin
            gfound = 1'b1;
            gidx   = idx[2:0];
         end
      end
      grant = gfound ? (ONE << gidx) : '0;
   end

   // Accept a new word when the holding register is free or draining.
   always_comb begin
      load_en  = (state == EMPTY) || out_ready;
      in_ready = (rst_n && !flush && load_en) ? grant : '0;
      take     = |(in_valid & in_ready);
   end

   assign out_valid = (state == FULL);

   // Holding register FSM, arbiter pointer and output transfer counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_src  <= '0;
         xfer_cnt <= '0;
         ptr      <= 3'(N_SRC - 1);
      end else if (flush) begin
         state    <= EMPTY;
         xfer_cnt <= '0;
      end else begin
         if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
         case (state)
            EMPTY: begin
               if (take) begin
                  state    <= FULL;
                  out_data <= in_data[int'(gidx)*DATA_W +: DATA_W];
                  out_src  <= gidx;
                  ptr      <= gidx;
               end
            end
            FULL: begin
               if (take) begin
                  out_data <= in_data[int'(gidx)*DATA_W +: DATA_W];
                  out_src  <= gidx;
                  ptr      <= gidx;
               end else if (out_ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_child_resp_collector.sv
// Scoreboard bench for child_resp_collector: directed stimulus
// pushes expected words, a negedge monitor pops and compares.
module tb_child_resp_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [4:0]  in_valid;
   logic [39:0] in_data;
   logic [4:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_src;
   logic        out_ready;
   logic [15:0] xfer_cnt;

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   child_resp_collector #(.DATA_W(8), .N_SRC(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      q.push_back(e);
   endtask

   // Monitor: every output handshake must match the next expected word.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual %0h required none",
                     out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_src", 32'(out_src), 32'(e.s));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout actual running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 5'b11111;
      in_data   = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready = 1'b1;

      // Reset state
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      cyc();
      rst_n = 1'b1;

      // All sources requesting: grants 0,1,2,3,4,0
      for (int k = 0; k < 6; k++) begin
         push(8'hA0 + 8'(k % 5), 3'(k % 5));
         @(negedge clk);
         chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 5)));
         cyc();
      end
      in_valid = 5'b0;
      cyc();
      @(negedge clk);
      chk("rr_drained", 32'(out_valid), 0);
      chk("rr_xfer_cnt", 32'(xfer_cnt), 6);

      // Hold under backpressure, then source 4
      cyc();
      out_ready = 1'b0;
      in_valid  = 5'b00100;
      in_data[16 +: 8] = 8'hA5;
      push(8'hA5, 3'd2);
      cyc();
      in_valid = 5'b10000;
      in_data[32 +: 8] = 8'h5A;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_out_data", 32'(out_data), 32'h A5);
         chk("bp_out_valid", 32'(out_valid), 1);
         cyc();
      end
      out_ready = 1'b1;
      push(8'h5A, 3'd4);
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'b10000);
      cyc();
      in_valid = 5'b0;
      @(negedge clk);
      chk("bp_next_src", 32'(out_src), 4);
      cyc();

      // Source 3 back-to-back, no bubble
      in_valid = 5'b01000;
      for (int k = 0; k < 3; k++) begin
         in_data[24 +: 8] = 8'h11 * 8'(k + 1);
         push(8'h11 * 8'(k + 1), 3'd3);
         @(negedge clk);
         chk("b2b_in_ready", 32'(in_ready), 32'b01000);
         cyc();
      end
      in_valid = 5'b0;
      @(negedge clk);
      chk("b2b_last_valid", 32'(out_valid), 1);
      cyc();
      @(negedge clk);
      chk("b2b_empty", 32'(out_valid), 0);
      chk("b2b_xfer_cnt", 32'(xfer_cnt), 11);
      cyc();

      // Flush while FULL with source 0 requesting
      out_ready = 1'b0;
      in_valid  = 5'b00001;
      in_data[0 +: 8] = 8'hC3;
      cyc();
      flush     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_full", 32'(out_valid), 1);
      cyc();
      flush    = 1'b0;
      in_valid = 5'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_xfer_cnt", 32'(xfer_cnt), 0);
      cyc();

      // Counter wrap after 65535 transfers
      in_valid = 5'b00010;
      in_data[8 +: 8] = 8'h77;
      for (int k = 0; k < 65535; k++) begin
         push(8'h77, 3'd1);
         cyc();
      end
      in_valid = 5'b0;
      cyc();
      @(negedge clk);
      chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
      cyc();
      in_valid = 5'b00010;
      push(8'h77, 3'd1);
      cyc();
      in_valid = 5'b0;
      cyc();
      @(negedge clk);
      chk("cnt_wrap", 32'(xfer_cnt), 0);
      cyc();

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      in_valid  = 5'b00100;
      in_data   = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
      cyc();
      in_valid = 5'b11111;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      chk("arst_out_data", 32'(out_data), 0);
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      push(8'hA0, 3'd0);
      @(negedge clk);
      chk("arst_first_grant", 32'(in_ready), 32'b00001);
      cyc();
      in_valid = 5'b0;
      cyc();
      @(negedge clk);
      chk("arst_xfer_cnt", 32'(xfer_cnt), 1);
      chk("queue_empty", 32'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
